// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up/down counter (00-99) with prescaled step tick,
// clear, parallel load and a wrap flag for the 7-segment board LED.
module bcd_counter_2d #(
    parameter int DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       wrap,
    output logic       tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] pre_q, pre_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          wrap_q, wrap_d;
    logic          tick_q, tick_d;

    always_comb begin
        pre_d  = pre_q;
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = wrap_q;
        tick_d = 1'b0;
        if (clr) begin
            pre_d  = '0;
            ones_d = 4'd0;
            tens_d = 4'd0;
            wrap_d = 1'b0;
        end else if (load) begin
            // Invalid nibbles collapse to 0 so the decoder never sees non-BCD
            pre_d  = '0;
            ones_d = (load_val[3:0] > 4'd9) ? 4'd0 : load_val[3:0];
            tens_d = (load_val[7:4] > 4'd9) ? 4'd0 : load_val[7:4];
            wrap_d = 1'b0;
        end else if (en) begin
            if (pre_q == LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                wrap_d = 1'b0;
                if (up) begin
                    if (ones_q < 4'd9) begin
                        ones_d = ones_q + 4'd1;
                    end else begin
                        ones_d = 4'd0;
                        if (tens_q < 4'd9) begin
                            tens_d = tens_q + 4'd1;
                        end else begin
                            tens_d = 4'd0;
                            wrap_d = 1'b1;
                        end
                    end
                end else begin
                    if (ones_q > 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = 4'd9;
                        if (tens_q > 4'd0) begin
                            tens_d = tens_q - 4'd1;
                        end else begin
                            tens_d = 4'd9;
                            wrap_d = 1'b1;
                        end
                    end
                end
            end else begin
                pre_d = pre_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            wrap_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ones_q <= ones_d;
            tens_q <= tens_d;
            wrap_q <= wrap_d;
            tick_q <= tick_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;
    assign wrap = wrap_q;
    assign tick = tick_q;

endmodule

// File: doc/bcd_counter_2d.md
Name: bcd_counter_2d

Overview:
Two-digit BCD up/down counter, 00-99, that sits directly upstream of the board's two-digit 7-segment decoder. A prescaler divides the system clock into a step tick. The block drives the ones digit, the tens digit, and a wrap indicator that the decoder passes through to an LED. It also supports synchronous clear, parallel load, enable and direction control.

Parameters:
DIV, 50000000, clock cycles per count step (1 Hz at 50 MHz); legal range >= 1; DIV=1 steps on every enabled cycle
CW, $clog2(DIV) (minimum 1), prescaler counter width; derived, never overridden

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; when low, prescaler and digits both freeze
up  input  1  direction: 1 counts up, 0 counts down; sampled on each tick
clr  input  1  synchronous clear to 00
load  input  1  synchronous parallel load
load_val  input  8  [7:4] tens BCD, [3:0] ones BCD
ones  output  4  ones digit, BCD 0-9; drives the decoder's low digit
tens  output  4  tens digit, BCD 0-9; drives the decoder's high digit
wrap  output  1  wrap indicator; drives the decoder's LED input
tick  output  1  one-cycle step strobe, for debug and bench use

Behaviour:
- Reset (rst=1 at a clock edge):
  - ones=0, tens=0, wrap=0, tick=0, prescaler=0.
  - Overrides every other input.
- Priority, per cycle: rst > clr > load > (en & prescaler step).
- Prescaler:
  - When en=1 and no clr/load, it increments each cycle.
  - When it equals DIV-1 it returns to 0, and tick=1 for exactly that one cycle.
  - When en=0 it holds its value and tick=0.
- Registered outputs: tick is registered, and the digit update happens on the same edge that registers tick=1. The new digits are therefore visible in the same cycle tick is high. Latency from the first enabled cycle to the first step is DIV cycles.
- Up step:
  - If ones<9: ones+1.
  - Else ones=0, and tens+1 if tens<9.
  - Else (99): tens=0, ones=0, and a wrap event occurs.
- Down step:
  - If ones>0: ones-1.
  - Else ones=9, and tens-1 if tens>0.
  - Else (00): 99, and a wrap event occurs.
- Direction change: up is sampled only on tick. Toggling it between ticks has no other effect.
- wrap:
  - Set to 1 on a tick that produces a wrap event.
  - Stays 1 until the next tick with no wrap event, so the LED stays lit for one full step period.
  - Cleared by rst, clr, or load.
- clr: ones=0, tens=0, wrap=0, prescaler=0, tick=0. Ignores en.
- load:
  - Digits take load_val; wrap=0, prescaler=0, tick=0. Ignores en.
  - Any nibble >9 loads as 0 for that digit only (e.g. 8'hA7 loads 07), so outputs are always valid BCD.
- load or clr in the same cycle a tick would occur: the tick is suppressed and the step is lost.
- Outputs never leave 0-9 per digit under any input sequence.

Test Plan:
- DIV=4, rst pulse, then en=1, up=1: tick every 4th cycle; digits step 00,01,...,09,10. Check ones=0 and tens=1 after the 10th tick; wrap=0 throughout.
- DIV=4, load 8'h98, up=1, en=1: after 1 tick 99; after 2 ticks 00 with wrap=1; wrap stays 1 for 4 cycles; after the 3rd tick 01 with wrap=0.
- DIV=4, load 8'h01, up=0: ticks give 00, then 99 with wrap=1, then 98 with wrap=0. Also load 8'h10 with up=0: one tick gives 09.
- DIV=4, count to 05, hold en=0 for 20 cycles: digits stay 05, tick stays 0; after re-enabling, the next tick gives 06 exactly 4 enabled cycles after the freeze point, because the prescaler resumes from its held value.
- DIV=1: the count advances every cycle. Assert clr coincident with a would-be tick at 57: next values are 00, 00 held for that cycle, then 01. Assert load 8'hFA: the digits read 00 (both nibbles invalid). Assert rst with load: the digits read 00 and rst wins.
- Random mix of en/up/clr/load for 10k cycles with DIV=3, checked against a reference model: ones and tens always <=9; wrap matches the model exactly.
